// File: rtl/popcnt_frame_acc.sv
`default_nettype none
// ============================================================================
// Module   : popcnt_frame_acc
// Brief    : Accumulates per-word popcounts over a frame and presents the
//            total, maximum, above-threshold count and word count per frame.
// Revision : 1.0 - initial release
// ============================================================================
module popcnt_frame_acc #(
    parameter int POS_W     = 4,
    parameter int FRAME_LEN = 8,
    parameter int THR       = 5,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1),
    parameter int ACC_W     = POS_W + $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [POS_W-1:0] in_sum,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [POS_W-1:0] out_max,
    output logic [CNT_W-1:0] out_above,
    output logic [CNT_W-1:0] out_words
);

    localparam logic [0:0]       c_st_accum  = 1'b0;
    localparam logic [0:0]       c_st_hold   = 1'b1;
    localparam logic [CNT_W-1:0] c_last_word = CNT_W'(FRAME_LEN - 1);
    // One extra bit so a threshold at the top of the in_sum range still compares correctly
    localparam logic [POS_W:0]   c_thr       = (POS_W + 1)'(THR);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;

    logic [ACC_W-1:0] r_acc_total;
    logic [POS_W-1:0] r_acc_max;
    logic [CNT_W-1:0] r_acc_above;
    logic [CNT_W-1:0] r_acc_words;

    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_total;
    logic [POS_W-1:0] r_out_max;
    logic [CNT_W-1:0] r_out_above;
    logic [CNT_W-1:0] r_out_words;

    logic             w_accept;
    logic             w_take;
    logic             w_close;
    logic             w_is_above;
    logic [ACC_W-1:0] w_total_nxt;
    logic [POS_W-1:0] w_max_nxt;
    logic [CNT_W-1:0] w_above_nxt;
    logic [CNT_W-1:0] w_words_nxt;

    // Gated by rst_n so the block refuses words while held in reset
    assign in_ready = rst_n && ((r_state == c_st_accum) || out_ready);

    // Working registers are zero whenever a frame is about to start, so the
    // same update path serves both ACCUM and the first word accepted in HOLD.
    always_comb begin
        w_accept    = in_valid && in_ready;
        w_take      = r_out_valid && out_ready;
        w_is_above  = {1'b0, in_sum} > c_thr;
        w_total_nxt = r_acc_total + ACC_W'(in_sum);
        w_max_nxt   = (in_sum > r_acc_max) ? in_sum : r_acc_max;
        w_above_nxt = r_acc_above + CNT_W'(w_is_above);
        w_words_nxt = r_acc_words + CNT_W'(1);
        w_close     = w_accept && (in_last || (r_acc_words == c_last_word));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_accum: if (w_close) w_state_nxt = c_st_hold;
            c_st_hold:  if (w_take && !w_close) w_state_nxt = c_st_accum;
            default:    w_state_nxt = c_st_accum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_accum;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_total <= '0;
            r_acc_max   <= '0;
            r_acc_above <= '0;
            r_acc_words <= '0;
            r_out_valid <= 1'b0;
            r_out_total <= '0;
            r_out_max   <= '0;
            r_out_above <= '0;
            r_out_words <= '0;
        end else begin
            if (w_accept) begin
                if (w_close) begin
                    r_acc_total <= '0;
                    r_acc_max   <= '0;
                    r_acc_above <= '0;
                    r_acc_words <= '0;
                end else begin
                    r_acc_total <= w_total_nxt;
                    r_acc_max   <= w_max_nxt;
                    r_acc_above <= w_above_nxt;
                    r_acc_words <= w_words_nxt;
                end
            end
            if (w_close) begin
                r_out_valid <= 1'b1;
                r_out_total <= w_total_nxt;
                r_out_max   <= w_max_nxt;
                r_out_above <= w_above_nxt;
                r_out_words <= w_words_nxt;
            end else if (w_take) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_total = r_out_total;
    assign out_max   = r_out_max;
    assign out_above = r_out_above;
    assign out_words = r_out_words;

endmodule
`default_nettype wire

// File: tb/tb_popcnt_frame_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_popcnt_frame_acc
// Brief    : Self-checking bench for popcnt_frame_acc: directed scenarios plus
//            randomized traffic against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_popcnt_frame_acc;

    localparam int POS_W     = 4;
    localparam int FRAME_LEN = 8;
    localparam int THR       = 5;
    localparam int CNT_W     = 4;
    localparam int ACC_W     = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [POS_W-1:0] in_sum = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_total;
    logic [POS_W-1:0] out_max;
    logic [CNT_W-1:0] out_above;
    logic [CNT_W-1:0] out_words;

    int n_checks = 0;
    int n_fail   = 0;

    popcnt_frame_acc #(
        .POS_W    (POS_W),
        .FRAME_LEN(FRAME_LEN),
        .THR      (THR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sum   (in_sum),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_total(out_total),
        .out_max  (out_max),
        .out_above(out_above),
        .out_words(out_words)
    );

    always #5 clk = ~clk;

    // Every task starts and ends 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int s, input logic l, input logic r);
        in_valid  = v;
        in_sum    = POS_W'(s);
        in_last   = l;
        out_ready = r;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({in_ready, out_valid, out_total, out_max, out_above, out_words} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%0b v=%0b tot=%0d max=%0d abv=%0d wrd=%0d, expected all 0",
                     in_ready, out_valid, out_total, out_max, out_above, out_words);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%0b v=%0b, expected rdy=1 v=0", in_ready, out_valid);
        end
        tick();
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i + 1, 1'b0, 1'b1);
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL full_frame_ready word %0d: got %0b expected 1", i, in_ready);
            end
            tick();
        end
        drive(1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_total, out_max, out_above, out_words} !== {1'b1, 7'd36, 4'd8, 4'd3, 4'd8}) begin
            n_fail++;
            $display("FAIL full_frame_result: v=%0b tot=%0d max=%0d abv=%0d wrd=%0d, expected v=1 tot=36 max=8 abv=3 wrd=8",
                     out_valid, out_total, out_max, out_above, out_words);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_frame_consumed: v=%0b expected 0", out_valid);
        end
        tick();
    endtask

    task automatic test_early_close();
        int vals[3] = '{6, 0, 10};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i], (i == 2), 1'b1);
            tick();
        end
        drive(1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_total, out_max, out_above, out_words} !== {1'b1, 7'd16, 4'd10, 4'd2, 4'd3}) begin
            n_fail++;
            $display("FAIL early_close_result: v=%0b tot=%0d max=%0d abv=%0d wrd=%0d, expected v=1 tot=16 max=10 abv=2 wrd=3",
                     out_valid, out_total, out_max, out_above, out_words);
        end
        tick();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 3, 1'b0, 1'b1);
        tick();
        drive(1'b1, 9, 1'b1, 1'b1);
        tick();
        drive(1'b1, 12, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({in_ready, out_valid, out_total, out_max, out_above, out_words} !==
                {1'b0, 1'b1, 7'd12, 4'd9, 4'd1, 4'd2}) begin
                n_fail++;
                $display("FAIL backpressure_hold cycle %0d: rdy=%0b v=%0b tot=%0d max=%0d abv=%0d wrd=%0d, expected rdy=0 v=1 tot=12 max=9 abv=1 wrd=2",
                         i, in_ready, out_valid, out_total, out_max, out_above, out_words);
            end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release_ready: got %0b expected 1", in_ready);
        end
        tick();
        drive(1'b1, 2, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL backpressure_taken: v=%0b rdy=%0b, expected v=0 rdy=1", out_valid, in_ready);
        end
        tick();
        drive(1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_total, out_max, out_above, out_words} !== {1'b1, 7'd14, 4'd12, 4'd1, 4'd2}) begin
            n_fail++;
            $display("FAIL backpressure_next_frame: v=%0b tot=%0d max=%0d abv=%0d wrd=%0d, expected v=1 tot=14 max=12 abv=1 wrd=2",
                     out_valid, out_total, out_max, out_above, out_words);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int vals[3]  = '{15, 0, 7};
        int above[3] = '{1, 0, 1};
        drive(1'b1, vals[0], 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(1'b1, vals[i + 1], 1'b1, 1'b1);
            else       drive(1'b0, 0, 1'b0, 1'b1);
            @(negedge clk);
            n_checks++;
            if ({out_valid, out_total, out_max, out_above, out_words} !==
                {1'b1, ACC_W'(vals[i]), POS_W'(vals[i]), CNT_W'(above[i]), 4'd1}) begin
                n_fail++;
                $display("FAIL back_to_back result %0d: v=%0b tot=%0d max=%0d abv=%0d wrd=%0d, expected v=1 tot=%0d max=%0d abv=%0d wrd=1",
                         i, out_valid, out_total, out_max, out_above, out_words, vals[i], vals[i], above[i]);
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_drain: v=%0b expected 0", out_valid);
        end
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, i, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_total, out_max, out_above, out_words} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_midframe: rdy=%0b v=%0b tot=%0d, expected all 0", in_ready, out_valid, out_total);
        end
        tick();
        rst_n = 1'b1;
        drive(1'b1, 4, 1'b0, 1'b1);
        tick();
        drive(1'b1, 4, 1'b1, 1'b1);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_total, out_max, out_above, out_words} !== {1'b1, 7'd8, 4'd4, 4'd0, 4'd2}) begin
            n_fail++;
            $display("FAIL async_reset_after: v=%0b tot=%0d max=%0d abv=%0d wrd=%0d, expected v=1 tot=8 max=4 abv=0 wrd=2",
                     out_valid, out_total, out_max, out_above, out_words);
        end
        // Reset again while the result is still held back
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_total, out_max, out_above, out_words} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_hold: rdy=%0b v=%0b tot=%0d max=%0d abv=%0d wrd=%0d, expected all 0",
                     in_ready, out_valid, out_total, out_max, out_above, out_words);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL async_reset_release: rdy=%0b v=%0b, expected rdy=1 v=0", in_ready, out_valid);
        end
        tick();
    endtask

    task automatic test_random();
        int               frame_q[$];
        logic             pending = 1'b0;
        logic             exp_ready;
        logic [ACC_W-1:0] exp_total = '0;
        logic [POS_W-1:0] exp_max = '0;
        logic [CNT_W-1:0] exp_above = '0;
        logic [CNT_W-1:0] exp_words = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
            exp_ready = !pending || out_ready;
            @(negedge clk);
            n_checks++;
            if ({in_ready, out_valid} !== {exp_ready, pending}) begin
                n_fail++;
                $display("FAIL random_handshake cyc %0d: rdy=%0b v=%0b, expected rdy=%0b v=%0b",
                         cyc, in_ready, out_valid, exp_ready, pending);
            end
            if (pending) begin
                n_checks++;
                if ({out_total, out_max, out_above, out_words} !== {exp_total, exp_max, exp_above, exp_words}) begin
                    n_fail++;
                    $display("FAIL random_result cyc %0d: tot=%0d max=%0d abv=%0d wrd=%0d, expected tot=%0d max=%0d abv=%0d wrd=%0d",
                             cyc, out_total, out_max, out_above, out_words, exp_total, exp_max, exp_above, exp_words);
                end
            end
            // Model what the coming edge does: retire result, then take the word
            if (pending && out_ready) pending = 1'b0;
            if (in_valid && exp_ready) begin
                frame_q.push_back(int'(in_sum));
                if (in_last || frame_q.size() == FRAME_LEN) begin
                    int s = 0, m = 0, a = 0;
                    foreach (frame_q[k]) begin
                        s += frame_q[k];
                        if (frame_q[k] > m) m = frame_q[k];
                        if (frame_q[k] > THR) a++;
                    end
                    exp_total = ACC_W'(s);
                    exp_max   = POS_W'(m);
                    exp_above = CNT_W'(a);
                    exp_words = CNT_W'(frame_q.size());
                    pending   = 1'b1;
                    frame_q.delete();
                end
            end
            tick();
        end
        drive(1'b0, 0, 1'b0, 1'b1);
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_early_close();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
